// File: rtl/seg_display_driver.sv
// Multi-digit 7-segment driver for the DE2 HEX displays.
// Accepts a binary word over valid/ready and shows it either in decimal
// (iterative double-dabble conversion) or in hex. The decimal path handles
// a sign, and both paths handle leading-zero blanking and overflow. All
// segment outputs are registered, so they can drive the HEX pins directly.
module seg_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int IN_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_WIDTH-1:0]     value,
  input  logic                    is_signed,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    valid,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segments
);

  // Enough decimal digits for 2^IN_WIDTH-1: floor(IN_WIDTH*log10(2))+1.
  // This is exact for IN_WIDTH <= 32.
  localparam int BCD_DIGITS = (IN_WIDTH * 301) / 1000 + 1;
  localparam int HEX_DIGITS = (IN_WIDTH + 3) / 4;
  localparam int SRC_DIGITS = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
  localparam int ARR_DIGITS = (SRC_DIGITS > NUM_DIGITS) ? SRC_DIGITS : NUM_DIGITS;
  localparam int CNT_W      = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

  state_t state, state_next;

  logic [IN_WIDTH-1:0]     mag_reg;
  logic [4*BCD_DIGITS-1:0] bcd_reg;
  logic                    neg_reg;
  logic                    hex_reg;
  logic                    blank_reg;
  logic [CNT_W-1:0]        cnt;

  logic                    accept;
  logic [IN_WIDTH-1:0]     mag_in;
  logic                    neg_in;
  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [4*BCD_DIGITS-1:0] bcd_shift;
  logic [IN_WIDTH-1:0]     mag_shift;
  logic [4*ARR_DIGITS-1:0] src_ext;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    ovf_next;
  int                      msd;
  int                      avail;

  // Active-low segment pattern for one digit value 0-F.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign accept = valid && ready;

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: decimal words go through the shift sequencer, hex words go straight to formatting.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = hex_mode ? FORMAT : CONV;
      CONV:    if (cnt == LAST_SHIFT) state_next = FORMAT;
      FORMAT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: only IDLE takes a new word.
  always_comb begin
    ready = (state == IDLE);
  end

  // Sign handling: in decimal mode a negative word becomes its magnitude (most negative fits unsigned).
  always_comb begin
    mag_in = value;
    neg_in = 1'b0;
    if (is_signed && !hex_mode && value[IN_WIDTH-1]) begin
      mag_in = -value;
      neg_in = 1'b1;
    end
  end

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd, magnitude} left.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
    {bcd_shift, mag_shift} = {bcd_adj, mag_reg} << 1;
  end

  // Build the displayed digits: pick the source nibbles, find the leading digit, detect overflow, place the sign.
  always_comb begin
    src_ext = '0;
    if (hex_reg) src_ext[IN_WIDTH-1:0]     = mag_reg;
    else         src_ext[4*BCD_DIGITS-1:0] = bcd_reg;

    msd = 0;
    for (int i = 0; i < ARR_DIGITS; i++) begin
      if (src_ext[4*i +: 4] != 4'd0) msd = i;
    end

    avail = neg_reg ? NUM_DIGITS - 1 : NUM_DIGITS;
    ovf_next = 1'b0;
    for (int i = 0; i < ARR_DIGITS; i++) begin
      if (src_ext[4*i +: 4] != 4'd0 && i >= avail) ovf_next = 1'b1;
    end

    seg_next = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (ovf_next)
        seg_next[7*j +: 7] = SEG_MINUS;
      else if (blank_reg) begin
        if (j <= msd)
          seg_next[7*j +: 7] = glyph(src_ext[4*j +: 4]);
        else if (neg_reg && j == msd + 1)
          seg_next[7*j +: 7] = SEG_MINUS;
        else
          seg_next[7*j +: 7] = SEG_BLANK;
      end else begin
        if (neg_reg && j == NUM_DIGITS - 1)
          seg_next[7*j +: 7] = SEG_MINUS;
        else
          seg_next[7*j +: 7] = glyph(src_ext[4*j +: 4]);
      end
    end
  end

  // Datapath: latch the request on accept, shift during CONV, and update the display only in FORMAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_reg   <= '0;
      bcd_reg   <= '0;
      neg_reg   <= 1'b0;
      hex_reg   <= 1'b0;
      blank_reg <= 1'b0;
      cnt       <= '0;
      segments  <= '1;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mag_reg   <= mag_in;
            neg_reg   <= neg_in;
            hex_reg   <= hex_mode;
            blank_reg <= blank_lz;
            bcd_reg   <= '0;
            cnt       <= '0;
          end
        end
        CONV: begin
          bcd_reg <= bcd_shift;
          mag_reg <= mag_shift;
          cnt     <= cnt + CNT_W'(1);
        end
        FORMAT: begin
          segments <= seg_next;
          overflow <= ovf_next;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
